ctrl_pipe_unit: RTL and testbench

- Successor to the decode-only control unit: decodes the ID-stage opcode into WB/M/EX control bundles and carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Adds load-use hazard detection with bubble insertion, branch flush, external freeze and illegal-opcode flagging.
- Sits beside the datapath pipeline registers; the datapath consumes the stage-aligned bundles.

---
 rtl/ctrl_pipe_pkg.sv | 42 ++++
 rtl/ctrl_pipe_unit_decode.sv | 67 ++++++
 rtl/ctrl_pipe_unit.sv | 173 +++++++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_pipe_pkg
// Brief   : Opcode, ALUOp and control-bundle bit-index constants for the
//           pipelined control unit.
// Revision: 1.0 - initial release
// ============================================================================
package ctrl_pipe_pkg;

    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_SLTI = 6'b001010;
    localparam logic [5:0] OPC_ANDI = 6'b001100;
    localparam logic [5:0] OPC_ORI  = 6'b001101;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_SLT   = 3'b100;
    localparam logic [2:0] ALUOP_AND   = 3'b101;
    localparam logic [2:0] ALUOP_OR    = 3'b111;

    localparam int EX_REGDST   = 0;
    localparam int M_BRANCH    = 0;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 2;
    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;

    typedef logic [2:0] m_bundle_t;
    typedef logic [1:0] wb_bundle_t;

    // ALUSrc sits just above the ALUOp field, so its index follows ALUOP_W.
    function automatic int ex_alusrc_idx(input int aluop_w);
        return aluop_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_pipe_unit_decode.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_decode
// Brief   : Combinational opcode decode into WB/M/EX bundles, illegal flag
//           and rt-usage flag.
// Revision: 1.0 - initial release
// ============================================================================
module ctrl_decode
    import ctrl_pipe_pkg::*;
#(
    parameter int ALUOP_W = 3
) (
    input  logic [5:0]         opc,
    output wb_bundle_t         wb,
    output m_bundle_t          m,
    output logic [ALUOP_W+1:0] ex,
    output logic               illegal,
    output logic               uses_rt
);

    always_comb begin
        wb      = '0;
        m       = '0;
        ex      = '0;
        illegal = 1'b0;
        uses_rt = 1'b0;
        case (opc)
            OPC_R: begin
                ex[EX_REGDST]    = 1'b1;
                ex[ALUOP_W:1]    = ALUOP_W'(ALUOP_RTYPE);
                wb[WB_REGWRITE]  = 1'b1;
                uses_rt          = 1'b1;
            end
            OPC_LW: begin
                ex[ex_alusrc_idx(ALUOP_W)] = 1'b1;
                ex[ALUOP_W:1]    = ALUOP_W'(ALUOP_ADD);
                m[M_MEMREAD]     = 1'b1;
                wb[WB_REGWRITE]  = 1'b1;
                wb[WB_MEMTOREG]  = 1'b1;
            end
            OPC_SW: begin
                ex[ex_alusrc_idx(ALUOP_W)] = 1'b1;
                ex[ALUOP_W:1]    = ALUOP_W'(ALUOP_ADD);
                m[M_MEMWRITE]    = 1'b1;
                uses_rt          = 1'b1;
            end
            OPC_BEQ: begin
                ex[ALUOP_W:1]    = ALUOP_W'(ALUOP_SUB);
                m[M_BRANCH]      = 1'b1;
                uses_rt          = 1'b1;
            end
            OPC_ADDI, OPC_SLTI, OPC_ANDI, OPC_ORI: begin
                ex[ex_alusrc_idx(ALUOP_W)] = 1'b1;
                wb[WB_REGWRITE]  = 1'b1;
                case (opc)
                    OPC_SLTI: ex[ALUOP_W:1] = ALUOP_W'(ALUOP_SLT);
                    OPC_ANDI: ex[ALUOP_W:1] = ALUOP_W'(ALUOP_AND);
                    OPC_ORI:  ex[ALUOP_W:1] = ALUOP_W'(ALUOP_OR);
                    default:  ex[ALUOP_W:1] = ALUOP_W'(ALUOP_ADD);
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_pipe_unit
// Brief   : Pipelined control unit: decode, ID/EX-EX/MEM-MEM/WB control
//           registers, load-use bubble, branch flush, external freeze.
//           Optional perf counters enabled by macro CTRL_PERF_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module ctrl_pipe_unit
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 3
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opc,
    input  logic               valid_id,
    input  logic [REG_W-1:0]   rs_id,
    input  logic [REG_W-1:0]   rt_id,
    input  logic               branch_taken_mem,
    input  logic               stall_ext,
    output logic [ALUOP_W+1:0] ex_ctrl,
    output logic               ex_illegal,
    output logic [2:0]         m_ctrl,
    output logic [1:0]         wb_ctrl,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ifid_flush
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
`endif
);

    wb_bundle_t         dec_wb;
    m_bundle_t          dec_m;
    logic [ALUOP_W+1:0] dec_ex;
    logic               dec_illegal;
    logic               dec_uses_rt;

    ctrl_decode #(.ALUOP_W(ALUOP_W)) u_decode (
        .opc     (opc),
        .wb      (dec_wb),
        .m       (dec_m),
        .ex      (dec_ex),
        .illegal (dec_illegal),
        .uses_rt (dec_uses_rt)
    );

    wb_bundle_t         idex_wb_q, idex_wb_d, exmem_wb_q, exmem_wb_d, memwb_wb_q, memwb_wb_d;
    m_bundle_t          idex_m_q, idex_m_d, exmem_m_q, exmem_m_d;
    logic [ALUOP_W+1:0] idex_ex_q, idex_ex_d;
    logic [REG_W-1:0]   idex_rt_q, idex_rt_d;
    logic               idex_ill_q, idex_ill_d;
    logic               hz;
    logic               pc_write_c, ifid_write_c, ifid_flush_c;

    assign hz = idex_m_q[M_MEMREAD] && (idex_rt_q != '0) &&
                ((idex_rt_q == rs_id) || ((idex_rt_q == rt_id) && dec_uses_rt));

    always_comb begin
        idex_wb_d    = idex_wb_q;
        idex_m_d     = idex_m_q;
        idex_ex_d    = idex_ex_q;
        idex_rt_d    = idex_rt_q;
        idex_ill_d   = idex_ill_q;
        exmem_wb_d   = exmem_wb_q;
        exmem_m_d    = exmem_m_q;
        memwb_wb_d   = memwb_wb_q;
        pc_write_c   = 1'b0;
        ifid_write_c = 1'b0;
        ifid_flush_c = 1'b0;
        if (stall_ext) begin
            // Frozen: MEM keeps asserting branch_taken_mem, so a pending flush replays later.
        end else if (branch_taken_mem) begin
            idex_wb_d    = '0;
            idex_m_d     = '0;
            idex_ex_d    = '0;
            idex_rt_d    = '0;
            idex_ill_d   = 1'b0;
            exmem_wb_d   = '0;
            exmem_m_d    = '0;
            memwb_wb_d   = exmem_wb_q;
            ifid_flush_c = 1'b1;
            pc_write_c   = 1'b1;
            ifid_write_c = 1'b1;
        end else begin
            exmem_wb_d   = idex_wb_q;
            exmem_m_d    = idex_m_q;
            memwb_wb_d   = exmem_wb_q;
            idex_wb_d    = '0;
            idex_m_d     = '0;
            idex_ex_d    = '0;
            idex_rt_d    = '0;
            idex_ill_d   = 1'b0;
            if (!hz) begin
                pc_write_c   = 1'b1;
                ifid_write_c = 1'b1;
                if (valid_id) begin
                    idex_wb_d  = dec_wb;
                    idex_m_d   = dec_m;
                    idex_ex_d  = dec_ex;
                    idex_rt_d  = rt_id;
                    idex_ill_d = dec_illegal;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_wb_q  <= '0;
            idex_m_q   <= '0;
            idex_ex_q  <= '0;
            idex_rt_q  <= '0;
            idex_ill_q <= 1'b0;
            exmem_wb_q <= '0;
            exmem_m_q  <= '0;
            memwb_wb_q <= '0;
        end else begin
            idex_wb_q  <= idex_wb_d;
            idex_m_q   <= idex_m_d;
            idex_ex_q  <= idex_ex_d;
            idex_rt_q  <= idex_rt_d;
            idex_ill_q <= idex_ill_d;
            exmem_wb_q <= exmem_wb_d;
            exmem_m_q  <= exmem_m_d;
            memwb_wb_q <= memwb_wb_d;
        end
    end

    assign ex_ctrl    = idex_ex_q;
    assign ex_illegal = idex_ill_q;
    assign m_ctrl     = exmem_m_q;
    assign wb_ctrl    = memwb_wb_q;
    assign pc_write   = rst_n & pc_write_c;
    assign ifid_write = rst_n & ifid_write_c;
    assign ifid_flush = rst_n & ifid_flush_c;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz && !stall_ext && !branch_taken_mem && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (ifid_flush_c && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_ctrl_pipe_unit
// Brief   : Self-checking bench for ctrl_pipe_unit (decode table with
//           scoreboard, plus hazard / flush / freeze / reset sequences).
// Revision: 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opc;
    logic       valid_id;
    logic [4:0] rs_id, rt_id;
    logic       branch_taken_mem, stall_ext;
    logic [4:0] ex_ctrl;
    logic       ex_illegal;
    logic [2:0] m_ctrl;
    logic [1:0] wb_ctrl;
    logic       pc_write, ifid_write, ifid_flush;
`ifdef CTRL_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    ctrl_pipe_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .opc              (opc),
        .valid_id         (valid_id),
        .rs_id            (rs_id),
        .rt_id            (rt_id),
        .branch_taken_mem (branch_taken_mem),
        .stall_ext        (stall_ext),
        .ex_ctrl          (ex_ctrl),
        .ex_illegal       (ex_illegal),
        .m_ctrl           (m_ctrl),
        .wb_ctrl          (wb_ctrl),
        .pc_write         (pc_write),
        .ifid_write       (ifid_write),
        .ifid_flush       (ifid_flush)
`ifdef CTRL_PERF_CNT_EN
        ,
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int         due;
        int         sel;
        logic [4:0] val;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [5:0] opc;
        logic       v;
        logic [4:0] ex;
        logic [2:0] m;
        logic [1:0] wb;
        logic       ill;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic sb_check();
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due == cyc) begin
                case (sbq[i].sel)
                    0:       chk("sb_ex_ctrl",    {11'd0, ex_ctrl},    {11'd0, sbq[i].val});
                    1:       chk("sb_ex_illegal", {15'd0, ex_illegal}, {11'd0, sbq[i].val});
                    2:       chk("sb_m_ctrl",     {13'd0, m_ctrl},     {11'd0, sbq[i].val});
                    default: chk("sb_wb_ctrl",    {14'd0, wb_ctrl},    {11'd0, sbq[i].val});
                endcase
                sbq.delete(i);
            end
        end
    endtask

    task automatic push(input vec_t v);
        sbq.push_back('{due: cyc + 1, sel: 0, val: v.ex});
        sbq.push_back('{due: cyc + 1, sel: 1, val: {4'd0, v.ill}});
        sbq.push_back('{due: cyc + 2, sel: 2, val: {2'd0, v.m}});
        sbq.push_back('{due: cyc + 3, sel: 3, val: {3'd0, v.wb}});
    endtask

    task automatic drive(input logic [5:0] o, input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic br, input logic st);
        opc = o; valid_id = v; rs_id = rs; rt_id = rt;
        branch_taken_mem = br; stall_ext = st;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        sb_check();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(6'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic chk_ctl(input string nm, input logic pw, input logic iw, input logic fl);
        chk({nm, "_pc_write"},   {15'd0, pc_write},   {15'd0, pw});
        chk({nm, "_ifid_write"}, {15'd0, ifid_write}, {15'd0, iw});
        chk({nm, "_ifid_flush"}, {15'd0, ifid_flush}, {15'd0, fl});
    endtask

    task automatic chk_pipe(input string nm, input logic [4:0] ex, input logic [2:0] m,
                            input logic [1:0] wb);
        chk({nm, "_ex_ctrl"}, {11'd0, ex_ctrl}, {11'd0, ex});
        chk({nm, "_m_ctrl"},  {13'd0, m_ctrl},  {13'd0, m});
        chk({nm, "_wb_ctrl"}, {14'd0, wb_ctrl}, {14'd0, wb});
    endtask

    initial begin
        vt[0] = '{6'b000000, 1'b1, 5'b00101, 3'b000, 2'b01, 1'b0};
        vt[1] = '{6'b001000, 1'b1, 5'b10000, 3'b000, 2'b01, 1'b0};
        vt[2] = '{6'b101011, 1'b1, 5'b10000, 3'b100, 2'b00, 1'b0};
        vt[3] = '{6'b100011, 1'b1, 5'b10000, 3'b010, 2'b11, 1'b0};
        vt[4] = '{6'b000100, 1'b1, 5'b00010, 3'b001, 2'b00, 1'b0};
        vt[5] = '{6'b001010, 1'b1, 5'b11000, 3'b000, 2'b01, 1'b0};
        vt[6] = '{6'b001100, 1'b1, 5'b11010, 3'b000, 2'b01, 1'b0};
        vt[7] = '{6'b111111, 1'b1, 5'b00000, 3'b000, 2'b00, 1'b1};
        vt[8] = '{6'b001101, 1'b1, 5'b11110, 3'b000, 2'b01, 1'b0};
        vt[9] = '{6'b000000, 1'b0, 5'b00000, 3'b000, 2'b00, 1'b0};

        rst_n = 1'b0;
        drive(6'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_pipe("reset", 5'd0, 3'd0, 2'd0);
        chk("reset_ex_illegal", {15'd0, ex_illegal}, 16'd0);
        chk_ctl("reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk_ctl("post_reset", 1'b1, 1'b1, 1'b0);

        // Decode table through the pipeline; rt=0 keeps every LW hazard-free.
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].opc, vt[i].v, 5'd0, 5'd0, 1'b0, 1'b0);
            chk("table_pc_write", {15'd0, pc_write}, 16'd1);
            push(vt[i]);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(6'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
            push(vt[9]);
            tick();
        end
        idle(3);
        chk("sb_empty", 16'(sbq.size()), 16'd0);

        // Load-use: LW rt=3 then R using rs=3.
        drive(6'b100011, 1'b1, 5'd0, 5'd3, 1'b0, 1'b0);
        tick();
        drive(6'b000000, 1'b1, 5'd3, 5'd0, 1'b0, 1'b0);
        chk_ctl("hz", 1'b0, 1'b0, 1'b0);
        tick();
        chk_pipe("hz_bubble", 5'b00000, 3'b010, 2'b00);
        drive(6'b000000, 1'b1, 5'd3, 5'd0, 1'b0, 1'b0);
        chk_ctl("hz_release", 1'b1, 1'b1, 1'b0);
        tick();
        chk_pipe("hz_resume", 5'b00101, 3'b000, 2'b11);
        idle(3);
`ifdef CTRL_PERF_CNT_EN
        chk("stall_cnt_a", stall_cnt, 16'd1);
`endif

        // LW to r0 never creates a hazard.
        drive(6'b100011, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(6'b000000, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
        chk_ctl("r0", 1'b1, 1'b1, 1'b0);
        tick();
        chk("r0_ex_ctrl", {11'd0, ex_ctrl}, 16'b00101);
        chk("r0_m_ctrl",  {13'd0, m_ctrl},  16'b010);
        idle(3);

        // Branch flush.
        drive(6'b000100, 1'b1, 5'd1, 5'd2, 1'b0, 1'b0);
        tick();
        drive(6'b001000, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("br_m_ctrl_beq", {13'd0, m_ctrl}, 16'b001);
        drive(6'b001101, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0);
        chk_ctl("br", 1'b1, 1'b1, 1'b1);
        tick();
        chk_pipe("br_flushed", 5'd0, 3'd0, 2'b00);
        idle(1);
        chk("br_wb_addi_gone", {14'd0, wb_ctrl}, 16'd0);
        idle(2);
`ifdef CTRL_PERF_CNT_EN
        chk("stall_cnt_c", stall_cnt, 16'd1);
        chk("flush_cnt_c", flush_cnt, 16'd1);
`endif

        // Branch + hazard under freeze: outputs hold, then the flush wins.
        drive(6'b000100, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(6'b100011, 1'b1, 5'd0, 5'd4, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(6'b000000, 1'b1, 5'd4, 5'd0, 1'b1, 1'b1);
            chk_ctl("frz", 1'b0, 1'b0, 1'b0);
            tick();
            chk_pipe("frz_hold", 5'b10000, 3'b001, 2'b00);
        end
        drive(6'b000000, 1'b1, 5'd4, 5'd0, 1'b1, 1'b0);
        chk_ctl("frz_drop", 1'b1, 1'b1, 1'b1);
        tick();
        chk_pipe("frz_flush", 5'd0, 3'd0, 2'b00);
        idle(3);
`ifdef CTRL_PERF_CNT_EN
        chk("stall_cnt_d", stall_cnt, 16'd1);
        chk("flush_cnt_d", flush_cnt, 16'd2);
`endif

        // Asynchronous reset in the middle of a pending hazard.
        drive(6'b100011, 1'b1, 5'd0, 5'd5, 1'b0, 1'b0);
        tick();
        drive(6'b000000, 1'b1, 5'd5, 5'd0, 1'b0, 1'b0);
        chk("pre_rst_ex_ctrl", {11'd0, ex_ctrl}, 16'b10000);
        #2;
        rst_n = 1'b0;
        #1;
        chk_pipe("async_rst", 5'd0, 3'd0, 2'd0);
        chk("async_rst_ex_illegal", {15'd0, ex_illegal}, 16'd0);
        chk_ctl("async_rst", 1'b0, 1'b0, 1'b0);
`ifdef CTRL_PERF_CNT_EN
        chk("async_rst_stall_cnt", stall_cnt, 16'd0);
        chk("async_rst_flush_cnt", flush_cnt, 16'd0);
`endif
        tick();
        rst_n = 1'b1;
        drive(6'b000000, 1'b1, 5'd5, 5'd0, 1'b0, 1'b0);
        chk_ctl("rst_release", 1'b1, 1'b1, 1'b0);
        tick();
        chk("rst_release_ex_ctrl", {11'd0, ex_ctrl}, 16'b00101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
